rr_arb_ctrl: RTL and testbench
==============================

Name: rr_arb_ctrl

Overview:
Sequential round-robin arbitration controller built around the programmable priority encoder, pp_enc.
- Holds the priority pointer that drives pp_enc's `in` port.
- Registers and locks the winning grant until the owner releases it or a hold timeout preempts it.
- Advances the pointer past the last owner, giving fair rotation among N requesters.
- Sits between the requesting masters and the shared resource.

Parameters:
N, 4, number of requesters (>=2)
MAX_HOLD, 8, maximum cycles a grant is held before preemption; 0 disables the timeout
PW, $clog2(N), pointer/owner index width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  N  request vector, level, one bit per master
done  input  N  release pulse; only the bit of the current owner is honoured
gnt  output  N  registered one-hot grant, held while locked
busy  output  1  high while a grant is locked (gnt != 0)
owner  output  PW  index of current owner; valid when busy
ptr  output  PW  current priority pointer (index of highest-priority requester)
preempt  output  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
Reset (rst_n low, async):
- State=IDLE; gnt=0, busy=0, owner=0, ptr=0, preempt=0, hold counter=0.
- Outputs go to these values immediately, without waiting for clk.

Encoder contract:
- pp_enc(in=ptr, req) gives highest priority to req[ptr], then ptr+1, ... wrapping mod N.
- It returns a one-hot gnt and an any_gnt flag; it is purely combinational.

State IDLE:
- If any_gnt, latch the encoder's one-hot into gnt, set owner to its index, clear the counter, go to GRANT.
- Latency: req seen at edge t -> gnt valid after edge t.
- Otherwise stay in IDLE with gnt=0.

State GRANT:
- Each cycle the counter increments, saturating at MAX_HOLD.
- Release condition, evaluated per cycle with this priority:
  1. done[owner]=1 -> normal release, preempt stays 0.
  2. req[owner]=0 -> normal release, preempt stays 0.
  3. MAX_HOLD!=0 and counter==MAX_HOLD-1, i.e. the grant has been held MAX_HOLD cycles -> preemptive release, preempt=1 for exactly one cycle.
- On any release at edge t:
  - gnt=0, busy=0, state=IDLE.
  - ptr=(owner+1) mod N; wrap from N-1 to 0.
- One mandatory dead cycle follows each release (bus turnaround). Earliest regrant is after edge t+1.
- done bits of non-owners are ignored in all states.
- done in IDLE is ignored.
- New or changed req bits during GRANT do not disturb the locked gnt.

Invariants:
- gnt is always zero or one-hot.
- busy == (gnt != 0).
- ptr changes only on a release edge.
- A granted master never holds more than MAX_HOLD consecutive cycles when MAX_HOLD>0.

Widths:
- Counter width is $clog2(MAX_HOLD+1), minimum 1.
- Pointer increment is computed in PW bits with an explicit wrap compare, so it is correct for non-power-of-two N.

Decomposition:
Shared package arb_pkg:
- State enum {IDLE, GRANT}.
- Function onehot_to_idx(N-bit) -> PW-bit.
- Function idx_inc_wrap(idx, N).
Sub-module:
- Instantiate the existing pp_enc #(.N(N)) for the combinational pick.
- The rest (FSM, counter, pointer register) stays in rr_arb_ctrl. Expected size is about 150-200 lines.

Test Plan:
1. Rotation (N=4, MAX_HOLD=0):
   - Stimulus: after reset, req=4'b1111; pulse done[owner] 3 cycles after each grant.
   - Required: grants 0001, 0010, 0100, 1000, 0001, each separated by one gnt=0 cycle.
   - Required: ptr steps 0->1->2->3->0.
2. Wrap priority:
   - Stimulus: from reset, grant and release requester 1 (ptr becomes 2), then req=4'b0011.
   - Required: gnt=0001 (wraps past 2,3), then after release ptr=1.
3. Timeout (MAX_HOLD=8):
   - Stimulus: req=4'b0100 held, done never asserted.
   - Required: gnt=0100 for exactly 8 cycles, preempt=1 for one cycle on release, ptr=3, regrant 0100 after the dead cycle.
4. Ignored and simultaneous events:
   - Stimulus A: while owner=0, done=4'b0010. Required: no effect.
   - Stimulus B: done[owner] on the same cycle the timeout would fire. Required: normal release with preempt=0.
5. Owner withdraws:
   - Stimulus: owner 3 drops req[3] with no done.
   - Required: gnt=0 after next edge, preempt=0, ptr=0.
6. Async reset mid-grant:
   - Stimulus: rst_n low between clock edges while gnt=1000, ptr=2.
   - Required: gnt=0, busy=0, ptr=0 immediately.
   - Required: after rst_n rises with req=4'b1000, gnt=1000 one edge later.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
//   arb_state_e    : controller state (IDLE, GRANT)
//   onehot_to_idx  : one-hot vector (up to MAX_N bits) -> bit index
//   idx_inc_wrap   : index + 1, wrapping to 0 at n (any n, not just powers of two)
package arb_pkg;

   localparam int unsigned MAX_N = 32;
   localparam int unsigned IDX_W = $clog2(MAX_N);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // OR-reduce the indices of set bits; exact for a one-hot or zero input.
   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < MAX_N; i++) begin
         if (oh[i]) idx = idx | IDX_W'(i);
      end
      return idx;
   endfunction

   // Explicit wrap compare so non-power-of-two n rotates correctly.
   function automatic logic [IDX_W-1:0] idx_inc_wrap(input logic [IDX_W-1:0] idx,
                                                     input int unsigned     n);
      if ((32'(idx) + 32'd1) >= n) return '0;
      return idx + IDX_W'(1);
   endfunction

endpackage : arb_pkg

// File: rtl/pp_enc.sv
// Programmable priority encoder (purely combinational).
//   in      : index of the highest-priority requester
//   req     : request vector
//   gnt     : one-hot pick; priority in, in+1, ... wrapping mod N
//   any_gnt : high when some request is set
module pp_enc #(
   parameter  int unsigned N  = 4,
   localparam int unsigned PW = $clog2(N)
) (
   input  logic [PW-1:0] in,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  gnt,
   output logic          any_gnt
);

   // Walk from the pointer around the ring; first set request wins.
   always_comb begin
      logic [PW:0]   sum;
      logic [PW-1:0] idx;
      gnt     = '0;
      any_gnt = 1'b0;
      sum     = '0;
      idx     = '0;
      for (int unsigned i = 0; i < N; i++) begin
         sum = {1'b0, in} + (PW+1)'(i);
         if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
         idx = PW'(sum);
         if (!any_gnt && req[idx]) begin
            gnt[idx] = 1'b1;
            any_gnt  = 1'b1;
         end
      end
   end

endmodule : pp_enc

// File: rtl/rr_arb_ctrl.sv
// Round-robin arbitration controller with grant lock and hold timeout.
//   clk, rst_n : clock, async active-low reset
//   req        : level requests, one per master
//   done       : release pulse; only the current owner's bit is honoured
//   gnt        : registered one-hot grant, held while locked
//   busy       : grant locked (gnt != 0)
//   owner      : index of current owner, valid when busy
//   ptr        : priority pointer fed to the encoder
//   preempt    : one-cycle pulse when a grant is revoked by timeout
module rr_arb_ctrl
   import arb_pkg::*;
#(
   parameter  int unsigned N        = 4,
   parameter  int unsigned MAX_HOLD = 8,
   localparam int unsigned PW       = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  done,
   output logic [N-1:0]  gnt,
   output logic          busy,
   output logic [PW-1:0] owner,
   output logic [PW-1:0] ptr,
   output logic          preempt
);

   localparam int unsigned CW        = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

   arb_state_e    state_q, state_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic          busy_q, busy_d;
   logic [PW-1:0] owner_q, owner_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic          preempt_q, preempt_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [N-1:0]  enc_gnt;
   logic          enc_any;
   logic          timeout_c;
   logic          release_c;

   // Combinational pick relative to the current pointer.
   pp_enc #(.N(N)) u_pp_enc (
      .in      (ptr_q),
      .req     (req),
      .gnt     (enc_gnt),
      .any_gnt (enc_any)
   );

   // Counter value at the edge that completes MAX_HOLD held cycles.
   assign timeout_c = (MAX_HOLD != 0) && (cnt_q == CW'(HOLD_LAST));

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      busy_d    = busy_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      preempt_d = 1'b0;
      cnt_d     = cnt_q;
      release_c = 1'b0;

      case (state_q)
         IDLE: begin
            if (enc_any) begin
               gnt_d   = enc_gnt;
               busy_d  = 1'b1;
               owner_d = PW'(onehot_to_idx(MAX_N'(enc_gnt)));
               cnt_d   = '0;
               state_d = GRANT;
            end else begin
               gnt_d  = '0;
               busy_d = 1'b0;
            end
         end

         GRANT: begin
            // Owner release beats withdrawal beats timeout.
            if (done[owner_q]) begin
               release_c = 1'b1;
            end else if (!req[owner_q]) begin
               release_c = 1'b1;
            end else if (timeout_c) begin
               release_c = 1'b1;
               preempt_d = 1'b1;
            end else if (cnt_q != CW'(MAX_HOLD)) begin
               cnt_d = cnt_q + CW'(1);
            end

            // Release always passes through IDLE for a dead cycle.
            if (release_c) begin
               gnt_d   = '0;
               busy_d  = 1'b0;
               cnt_d   = '0;
               ptr_d   = PW'(idx_inc_wrap(IDX_W'(owner_q), N));
               state_d = IDLE;
            end
         end

         default: begin
            gnt_d   = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         owner_q   <= '0;
         ptr_q     <= '0;
         preempt_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         preempt_q <= preempt_d;
         cnt_q     <= cnt_d;
      end
   end

   assign gnt     = gnt_q;
   assign busy    = busy_q;
   assign owner   = owner_q;
   assign ptr     = ptr_q;
   assign preempt = preempt_q;

endmodule : rr_arb_ctrl

// File: tb/tb_rr_arb_ctrl.sv
// Directed bench for rr_arb_ctrl: one instance without timeout (rotation,
// wrap priority) and one with MAX_HOLD=8 (timeout, ignored done, withdraw,
// async reset).
module tb_rr_arb_ctrl;

   logic       clk;
   logic       rst_n;

   logic [3:0] req0, done0, gnt0;
   logic       busy0, preempt0;
   logic [1:0] owner0, ptr0;

   logic [3:0] req8, done8, gnt8;
   logic       busy8, preempt8;
   logic [1:0] owner8, ptr8;

   int total;
   int bad;

   rr_arb_ctrl #(.N(4), .MAX_HOLD(0)) u_dut0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req0),
      .done    (done0),
      .gnt     (gnt0),
      .busy    (busy0),
      .owner   (owner0),
      .ptr     (ptr0),
      .preempt (preempt0)
   );

   rr_arb_ctrl #(.N(4), .MAX_HOLD(8)) u_dut8 (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req8),
      .done    (done8),
      .gnt     (gnt8),
      .busy    (busy8),
      .owner   (owner8),
      .ptr     (ptr8),
      .preempt (preempt8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] e;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      req0  = '0;
      done0 = '0;
      req8  = '0;
      done8 = '0;

      // Reset state
      #2;
      check("rst_gnt0",  32'(gnt0), 'h0);
      check("rst_busy0", 32'(busy0), 'h0);
      check("rst_ptr0",  32'(ptr0), 'h0);
      check("rst_gnt8",  32'(gnt8), 'h0);
      check("rst_own8",  32'(owner8), 'h0);
      check("rst_pre8",  32'(preempt8), 'h0);

      @(negedge clk);
      rst_n = 1'b1;
      req0  = 4'b1111;
      tick();

      // 1. Rotation with all requesting, done 3 cycles after each grant
      for (int k = 0; k < 5; k++) begin
         e = 4'(1 << (k % 4));
         check("rot_gnt",   32'(gnt0), 32'(e));
         check("rot_owner", 32'(owner0), 32'(k % 4));
         check("rot_ptr",   32'(ptr0), 32'(k % 4));
         check("rot_busy",  32'(busy0), 'h1);
         tick();
         tick();
         check("rot_hold",  32'(gnt0), 32'(e));
         done0 = e;
         tick();
         done0 = '0;
         check("rot_rel_gnt",  32'(gnt0), 'h0);
         check("rot_rel_busy", 32'(busy0), 'h0);
         check("rot_rel_ptr",  32'(ptr0), 32'((k + 1) % 4));
         check("rot_rel_pre",  32'(preempt0), 'h0);
         tick();
      end

      // 2. Wrap priority: owner 1 releases (ptr=2), then only 0 and 1 request
      check("wrap_own1", 32'(gnt0), 'h2);
      done0 = 4'b0010;
      tick();
      done0 = '0;
      req0  = 4'b0011;
      check("wrap_ptr2", 32'(ptr0), 'h2);
      tick();
      check("wrap_gnt", 32'(gnt0), 'h1);
      done0 = 4'b0001;
      tick();
      done0 = '0;
      req0  = '0;
      check("wrap_ptr_after", 32'(ptr0), 'h1);
      check("wrap_gnt_off",   32'(gnt0), 'h0);
      tick();

      // 3. Timeout: requester 2 held, no done
      req8 = 4'b0100;
      tick();
      for (int c = 0; c < 8; c++) begin
         check("to_hold_gnt", 32'(gnt8), 'h4);
         check("to_hold_pre", 32'(preempt8), 'h0);
         if (c < 7) tick();
      end
      tick();
      check("to_rel_gnt",  32'(gnt8), 'h0);
      check("to_rel_busy", 32'(busy8), 'h0);
      check("to_rel_pre",  32'(preempt8), 'h1);
      check("to_rel_ptr",  32'(ptr8), 'h3);
      tick();
      check("to_regrant",  32'(gnt8), 'h4);
      check("to_pre_off",  32'(preempt8), 'h0);

      // 4A. Non-owner done is ignored
      done8 = 4'b0100;
      tick();
      done8 = '0;
      req8  = 4'b0001;
      check("ig_ptr3", 32'(ptr8), 'h3);
      tick();
      check("ig_gnt0", 32'(gnt8), 'h1);
      check("ig_own0", 32'(owner8), 'h0);
      done8 = 4'b0010;
      tick();
      done8 = '0;
      check("ig_gnt_kept", 32'(gnt8), 'h1);
      check("ig_ptr_kept", 32'(ptr8), 'h3);

      // 4B. done on the timeout edge is a normal release
      for (int c = 0; c < 6; c++) tick();
      check("sim_pre_hold", 32'(gnt8), 'h1);
      done8 = 4'b0001;
      tick();
      done8 = '0;
      check("sim_gnt", 32'(gnt8), 'h0);
      check("sim_pre", 32'(preempt8), 'h0);
      check("sim_ptr", 32'(ptr8), 'h1);

      // 5. Owner 3 withdraws its request
      req8 = 4'b1000;
      tick();
      check("wd_gnt", 32'(gnt8), 'h8);
      check("wd_own", 32'(owner8), 'h3);
      tick();
      req8 = '0;
      tick();
      check("wd_rel_gnt", 32'(gnt8), 'h0);
      check("wd_rel_pre", 32'(preempt8), 'h0);
      check("wd_rel_ptr", 32'(ptr8), 'h0);
      tick();

      // 6. Async reset while gnt=1000 and ptr=2
      req8 = 4'b0010;
      tick();
      check("ar_gnt1", 32'(gnt8), 'h2);
      done8 = 4'b0010;
      tick();
      done8 = '0;
      req8  = 4'b1000;
      tick();
      check("ar_gnt8", 32'(gnt8), 'h8);
      check("ar_ptr2", 32'(ptr8), 'h2);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_now_gnt",  32'(gnt8), 'h0);
      check("ar_now_busy", 32'(busy8), 'h0);
      check("ar_now_ptr",  32'(ptr8), 'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ar_idle_gnt", 32'(gnt8), 'h0);
      tick();
      check("ar_regrant", 32'(gnt8), 'h8);
      check("ar_busy",    32'(busy8), 'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_rr_arb_ctrl
